shift_seq8: RTL and testbench



---
 rtl/shift_seq8.sv | 128 ++++++++++++
 tb/tb_shift_seq8.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_seq8.sv
// Multi-cycle 8-bit shift sequencer: applies a 0-7 position shift in steps of at most 3 per cycle.
// Optional macro SHIFT_ROTATE_EN turns op 11 into ROR; otherwise op 11 is a one-step NOP.
module shift_seq8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] shamt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // One step of the selected shift; ASR re-reads bit 7 each step so the sign keeps replicating.
  function automatic logic [7:0] step_shift(input logic [7:0] w, input logic [1:0] op_v,
                                            input logic [1:0] amt);
`ifdef SHIFT_ROTATE_EN
    logic [15:0] rot;
`endif
    case (op_v)
      OP_LSL:  return w << amt;
      OP_LSR:  return w >> amt;
      OP_ASR:  return $unsigned($signed(w) >>> amt);
`ifdef SHIFT_ROTATE_EN
      OP_ROR: begin
        rot = {w, w} >> amt;
        return rot[7:0];
      end
`endif
      default: return w;
    endcase
  endfunction

  logic [1:0] state_r;
  logic [7:0] work_r;
  logic [1:0] op_r;
  logic [2:0] rem_r;
  logic [7:0] d_out_r;
  logic       busy_r;
  logic       done_r;

  logic [2:0] cap_amt_s;
  logic [1:0] step_s;
  logic [2:0] rem_next_s;
  logic [7:0] shifted_s;

`ifdef SHIFT_ROTATE_EN
  assign cap_amt_s = shamt;
`else
  assign cap_amt_s = (op == OP_ROR) ? 3'd0 : shamt;
`endif

  // Step size, remaining count after this step and the shifted work value.
  always_comb begin
    step_s = 2'd0;
    if (rem_r > 3'd3) begin
      step_s = 2'd3;
    end else begin
      step_s = rem_r[1:0];
    end
    rem_next_s = rem_r - {1'b0, step_s};
    shifted_s  = step_shift(work_r, op_r, step_s);
  end

  // Sequencer state, operand registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      work_r  <= 8'h00;
      op_r    <= 2'b00;
      rem_r   <= 3'd0;
      d_out_r <= 8'h00;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            work_r  <= d_in;
            op_r    <= op;
            rem_r   <= cap_amt_s;
            busy_r  <= 1'b1;
            state_r <= ST_SHIFT;
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          work_r <= shifted_s;
          rem_r  <= rem_next_s;
          if (rem_next_s == 3'd0) begin
            d_out_r <= shifted_s;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            done_r <= 1'b0;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_out = d_out_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_shift_seq8.sv
// Self-checking bench for shift_seq8: cycle-level reference model plus directed literal checks.
// Honours SHIFT_ROTATE_EN the same way as the design.
module tb_shift_seq8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [2:0] shamt = 3'd0;
  logic [7:0] d_in = 8'h00;
  logic [7:0] d_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass = 0;

  shift_seq8 dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .shamt(shamt),
    .d_in(d_in), .d_out(d_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-shift result computed directly from the full amount.
  function automatic logic [7:0] ref_result(input logic [1:0] o, input logic [7:0] d,
                                            input logic [2:0] s);
    logic [15:0] dd;
    int sh;
    sh = s;
    dd = {d, d};
    case (o)
      2'b00: return d << sh;
      2'b01: return d >> sh;
      2'b10: return $unsigned($signed(d) >>> sh);
      default: begin
`ifdef SHIFT_ROTATE_EN
        dd = dd >> sh;
        return dd[7:0];
`else
        return d;
`endif
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [2:0] s);
    int a;
    a = s;
`ifndef SHIFT_ROTATE_EN
    if (o == 2'b11) a = 0;
`endif
    if (a == 0) return 1;
    return (a + 2) / 3;
  endfunction

  // Reference model: edges left until completion, expected outputs.
  int         m_left;
  logic       m_busy, m_done;
  logic [7:0] m_dout, m_res;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_dout <= 8'h00; m_res <= 8'h00;
    end else if (m_done) begin
      m_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_dout <= m_res;
      end
    end else if (start) begin
      m_busy <= 1'b1;
      m_left <= ref_latency(op, shamt);
      m_res  <= ref_result(op, d_in, shamt);
    end
  end

  always @(negedge clk) begin
    check("cyc_d_out", {24'h0, d_out}, {24'h0, m_dout});
    check("cyc_busy", {31'h0, busy}, {31'h0, m_busy});
    check("cyc_done", {31'h0, done}, {31'h0, m_done});
  end

  // Issue one request; optionally hammer start with a different operand while busy.
  task automatic run_op(input string name, input logic [1:0] o, input logic [7:0] d,
                        input logic [2:0] s, input logic [7:0] exp_val, input int exp_n,
                        input bit poke);
    int k;
    op = o; d_in = d; shamt = s; start = 1'b1;
    @(posedge clk); #1;
    if (poke) begin
      op = 2'b00; d_in = 8'hFF; shamt = 3'd1;
    end else begin
      start = 1'b0;
    end
    k = 0;
    while (k < 10) begin
      @(posedge clk); #1;
      k++;
      if (done) break;
    end
    start = 1'b0;
    check({name, "_done_seen"}, {31'h0, done}, 32'h1);
    check({name, "_latency"}, k, exp_n);
    check({name, "_d_out"}, {24'h0, d_out}, {24'h0, exp_val});
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    check("rst_d_out", {24'h0, d_out}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_d_out", {24'h0, d_out}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);

    run_op("lsr_b4_5", 2'b01, 8'hB4, 3'd5, 8'h05, 2, 1'b0);
    run_op("lsl_b4_5", 2'b00, 8'hB4, 3'd5, 8'h80, 2, 1'b0);
    run_op("asr_80_7", 2'b10, 8'h80, 3'd7, 8'hFF, 3, 1'b0);
    run_op("asr_7e_4", 2'b10, 8'h7E, 3'd4, 8'h07, 2, 1'b0);
    run_op("lsl_81_0", 2'b00, 8'h81, 3'd0, 8'h81, 1, 1'b0);
    run_op("ignore_busy", 2'b10, 8'h80, 3'd7, 8'hFF, 3, 1'b1);
`ifdef SHIFT_ROTATE_EN
    run_op("ror_81_1", 2'b11, 8'h81, 3'd1, 8'hC0, 1, 1'b0);
    run_op("ror_81_7", 2'b11, 8'h81, 3'd7, 8'h03, 3, 1'b0);
`else
    run_op("nop_81_1", 2'b11, 8'h81, 3'd1, 8'h81, 1, 1'b0);
    run_op("nop_81_7", 2'b11, 8'h81, 3'd7, 8'h81, 1, 1'b0);
`endif

    // Reset between E1 and E2 of a three-step operation.
    op = 2'b10; d_in = 8'h80; shamt = 3'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("midrst_d_out", {24'h0, d_out}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    @(posedge clk); #3 reset = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check("midrst_no_done", {31'h0, done}, 32'h0);
    end
    run_op("after_rst", 2'b10, 8'h80, 3'd7, 8'hFF, 3, 1'b0);

    for (int i = 0; i < 200; i++) begin
      logic [1:0] ro;
      logic [7:0] rd;
      logic [2:0] rs;
      ro = 2'($urandom_range(3, 0));
      rd = 8'($urandom);
      rs = 3'($urandom_range(7, 0));
      run_op("rand", ro, rd, rs, ref_result(ro, rd, rs), ref_latency(ro, rs),
             $urandom_range(3, 0) == 0);
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
